// File: rtl/barcode_rx.sv
// Self-timed serial station-ID receiver: learns half-bit time from the start bit, samples 8 bits MSB first.
// Optional mid-frame watchdog enabled by defining BARCODE_RX_TIMEOUT_EN.
module barcode_rx #(
  parameter int              CNT_W   = 22,
  parameter logic [CNT_W-1:0] TIMEOUT = 22'h3FFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld,
  output logic       frm_err,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, WAIT_FALL, SAMPLE, DONE} state_t;

  state_t           state;
  logic             bc_p0, bc_p1, bc_p2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] t_half;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift;
  logic             fall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage p0/p1: synchronizer, p2: previous synchronised value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_p0 <= 1'b1;
      bc_p1 <= 1'b1;
      bc_p2 <= 1'b1;
    end else begin
      bc_p0 <= BC;
      bc_p1 <= bc_p0;
      bc_p2 <= bc_p1;
    end
  end

  assign fall = bc_p2 & ~bc_p1;
  assign busy = (state != IDLE);

`ifdef BARCODE_RX_TIMEOUT_EN
  logic [CNT_W-1:0] wd;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      t_half  <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      ID      <= 8'h00;
      ID_vld  <= 1'b0;
      frm_err <= 1'b0;
`ifdef BARCODE_RX_TIMEOUT_EN
      wd      <= '0;
`endif
    end else begin
      frm_err <= 1'b0;
      // A DONE-accept later in this block overrides the clear
      if (clr_ID_vld) ID_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (!bc_p1) begin
            cnt <= sat_inc(cnt);
          end else begin
            t_half  <= cnt;
            bit_cnt <= '0;
            if (cnt < CNT_W'(2)) begin
              frm_err <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= WAIT_FALL;
            end
          end
        end
        WAIT_FALL: begin
          if (fall) begin
            cnt   <= '0;
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          cnt <= sat_inc(cnt);
          if (cnt == t_half) begin
            shift   <= {shift[6:0], bc_p1};
            bit_cnt <= bit_cnt + 4'd1;
            state   <= (bit_cnt == 4'd7) ? DONE : WAIT_FALL;
          end
        end
        DONE: begin
          if (shift[7:6] == 2'b00) begin
            ID     <= shift;
            ID_vld <= 1'b1;
          end else begin
            frm_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef BARCODE_RX_TIMEOUT_EN
      // Watchdog runs only mid-frame and restarts on every falling edge
      if (state == START || state == WAIT_FALL || state == SAMPLE) begin
        if (fall) begin
          wd <= '0;
        end else if (wd == TIMEOUT) begin
          wd      <= '0;
          frm_err <= 1'b1;
          state   <= IDLE;
        end else begin
          wd <= wd + 1'b1;
        end
      end else begin
        wd <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_barcode_rx.sv
// Directed bench for barcode_rx: a behavioural transmitter drives BC, results checked with immediate assertions.
module tb_barcode_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       BC = 1'b1;
  logic       clr_ID_vld = 1'b0;
  logic [7:0] ID;
  logic       ID_vld;
  logic       frm_err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic seen_vld = 1'b0;
  logic vld_dropped = 1'b0;
  logic watch_vld = 1'b0;

  barcode_rx #(.CNT_W(22), .TIMEOUT(22'd1000)) dut (
    .clk(clk), .rst(rst), .BC(BC), .clr_ID_vld(clr_ID_vld),
    .ID(ID), .ID_vld(ID_vld), .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_err === 1'b1) err_pulses++;
    if (ID_vld === 1'b1) seen_vld = 1'b1;
    if (watch_vld && ID_vld !== 1'b1) vld_dropped = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start bit: low p/2 then high p/2. Bit 1: low p/4, bit 0: low 3p/4, rest of period high.
  task automatic send_frame(input logic [7:0] id, input int p, input int nbits);
    int lo;
    BC = 1'b0;
    repeat (p/2) @(negedge clk);
    BC = 1'b1;
    repeat (p/2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      lo = id[7-i] ? p/4 : (3*p)/4;
      BC = 1'b0;
      repeat (lo) @(negedge clk);
      BC = 1'b1;
      repeat (p - lo) @(negedge clk);
    end
  endtask

  initial begin
    int e0;
    int waited;

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle line after reset
    e0 = err_pulses;
    repeat (1000) @(negedge clk);
    check("reset_id", ID, 8'h00);
    check("reset_vld", ID_vld, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("idle_no_err", err_pulses - e0, 0);

    // Basic frame, then consumer clear
    send_frame(8'h01, 64, 8);
    repeat (10) @(negedge clk);
    check("f01_id", ID, 8'h01);
    check("f01_vld", ID_vld, 1'b1);
    check("f01_busy", busy, 1'b0);
    clr_ID_vld = 1'b1;
    @(negedge clk);
    clr_ID_vld = 1'b0;
    @(negedge clk);
    check("clr_vld", ID_vld, 1'b0);
    check("clr_id_kept", ID, 8'h01);

    // Back-to-back frames without clear: overwrite, flag stays high
    send_frame(8'h2A, 64, 8);
    repeat (10) @(negedge clk);
    check("f2a_id", ID, 8'h2A);
    check("f2a_vld", ID_vld, 1'b1);
    vld_dropped = 1'b0;
    watch_vld = 1'b1;
    send_frame(8'h15, 64, 8);
    repeat (10) @(negedge clk);
    watch_vld = 1'b0;
    check("f15_id", ID, 8'h15);
    check("f15_vld_held", vld_dropped, 1'b0);

    // Out-of-range ID rejected
    e0 = err_pulses;
    send_frame(8'hC5, 64, 8);
    repeat (10) @(negedge clk);
    check("fc5_err_once", err_pulses - e0, 1);
    check("fc5_id_kept", ID, 8'h15);
    check("fc5_vld_kept", ID_vld, 1'b1);

    // Fast frame with clear held: the accept cycle must still raise ID_vld
    clr_ID_vld = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_held_vld", ID_vld, 1'b0);
    seen_vld = 1'b0;
    send_frame(8'h3F, 16, 8);
    repeat (10) @(negedge clk);
    check("f3f_id", ID, 8'h3F);
    check("f3f_set_wins", seen_vld, 1'b1);
    check("f3f_cleared_after", ID_vld, 1'b0);
    clr_ID_vld = 1'b0;

    // Slow frame: timing relearned
    send_frame(8'h07, 128, 8);
    repeat (10) @(negedge clk);
    check("f07_id", ID, 8'h07);
    check("f07_vld", ID_vld, 1'b1);

    // Reset mid-frame
    send_frame(8'h12, 64, 3);
    BC = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_id", ID, 8'h00);
    check("rst_vld", ID_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", frm_err, 1'b0);
    BC = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h09, 64, 8);
    repeat (10) @(negedge clk);
    check("f09_id", ID, 8'h09);
    check("f09_vld", ID_vld, 1'b1);
    check("f09_busy", busy, 1'b0);

    // Truncated frame
    e0 = err_pulses;
    send_frame(8'hA0, 64, 4);
    waited = 0;
`ifdef BARCODE_RX_TIMEOUT_EN
    while (err_pulses == e0 && waited < 1300) begin
      @(negedge clk);
      waited++;
    end
    check("to_err_once", err_pulses - e0, 1);
    check("to_not_early", (waited >= 900) ? 1 : 0, 1);
    @(negedge clk);
    check("to_busy", busy, 1'b0);
    check("to_id_kept", ID, 8'h09);
    check("to_vld_kept", ID_vld, 1'b1);
`else
    repeat (1500) @(negedge clk);
    check("trunc_busy_hangs", busy, 1'b1);
    check("trunc_no_err", err_pulses - e0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("trunc_rst_busy", busy, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
